// File: rtl/st_instruction.sv
// Store-instruction sequencer: captures a store request, range-checks the
// address, drives a memory write until acknowledged or timed out, and reports
// done/err with a running count of successful stores.
module st_instruction #(
    parameter int unsigned       ADDR_W     = 19,
    parameter int unsigned       DATA_W     = 19,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(511),
    parameter int unsigned       TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] memory_addr,
    input  logic [DATA_W-1:0] r1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       store_count
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  tcnt;
    logic [CNT_W-1:0]  tcnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic [15:0]       count_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ack wins over timeout in the same WRITE cycle
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_CHECK;
            ST_CHECK: next_state = (mem_addr > ADDR_LIMIT) ? ST_ERR : ST_WRITE;
            ST_WRITE: begin
                if (mem_ack) begin
                    next_state = ST_DONE;
                end else if (tcnt == CNT_LAST) begin
                    next_state = ST_ERR;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_ERR:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output/datapath next values, decoded from the upcoming state so the
    // registered outputs line up with the state they describe
    always_comb begin
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        tcnt_d  = '0;
        count_d = store_count;
        we_d    = (next_state == ST_WRITE);
        busy_d  = (next_state != ST_IDLE);
        done_d  = (next_state == ST_DONE);
        err_d   = (next_state == ST_ERR);
        if (state == ST_IDLE && start) begin
            addr_d  = memory_addr;
            wdata_d = r1;
        end
        if (state == ST_WRITE && next_state == ST_WRITE) begin
            tcnt_d = tcnt + CNT_W'(1);
        end
        if (next_state == ST_DONE) begin
            count_d = store_count + 16'd1;
        end
    end

    // Registered outputs, captured operands and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            store_count <= 16'd0;
            tcnt        <= '0;
        end else begin
            mem_we      <= we_d;
            mem_addr    <= addr_d;
            mem_wdata   <= wdata_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            store_count <= count_d;
            tcnt        <= tcnt_d;
        end
    end

endmodule

// File: doc/st_instruction.md
ST_INSTRUCTION -- requirements
Module: st_instruction

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, meaning memory address width.
REQ-002 SHALL have parameter DATA_W, default 19, meaning register/memory data width.
REQ-003 SHALL have parameter ADDR_LIMIT, default 19'd511, meaning highest writable address.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning maximum WRITE cycles awaiting mem_ack.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  store request, single-cycle pulse or level.
REQ-008 SHALL have port memory_addr  input  ADDR_W  target address of the store.
REQ-009 SHALL have port r1  input  DATA_W  source register value to store.
REQ-010 SHALL have port mem_we  output  1  memory write strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  address presented to memory.
REQ-012 SHALL have port mem_wdata  output  DATA_W  data presented to memory.
REQ-013 SHALL have port mem_ack  input  1  memory write acknowledge.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on successful store.
REQ-016 SHALL have port err  output  1  one-cycle pulse on range error or timeout.
REQ-017 SHALL have port store_count  output  16  number of successful stores.

Function
REQ-018 SHALL implement FSM states IDLE, CHECK, WRITE, DONE, ERR.
REQ-019 SHALL, in IDLE with start=1, register memory_addr and r1 into internal address/data registers and move to CHECK.
REQ-020 SHALL, in CHECK, go to ERR if registered address > ADDR_LIMIT (mem_we never asserted), else to WRITE.
REQ-021 SHALL hold mem_we=1, mem_addr=registered address, mem_wdata=registered data in every WRITE cycle; mem_we=0 in all other states.
REQ-022 SHALL keep mem_addr/mem_wdata stable throughout WRITE regardless of memory_addr/r1 changes.
REQ-023 SHALL, in WRITE with mem_ack=1 sampled, go to DONE; mem_we low from the following cycle.
REQ-024 SHALL count WRITE cycles without ack from 0; on the TIMEOUT-th such cycle without ack, go to ERR.
REQ-025 SHALL give ack priority over timeout when both occur in the same cycle (go to DONE).
REQ-026 SHALL assert done for exactly the DONE cycle, increment store_count by 1 (wrapping 16'hFFFF -> 0), then return to IDLE.
REQ-027 SHALL assert err for exactly the ERR cycle, leave store_count unchanged, then return to IDLE.
REQ-028 SHALL ignore start in any state other than IDLE; no queuing.
REQ-029 SHALL ignore mem_ack outside WRITE.
REQ-030 SHALL give latency: start sampled at edge N -> mem_we high from N+2; ack sampled at edge M -> done high M+1..M+2; next start accepted at edge M+2.
REQ-031 SHALL accept address exactly ADDR_LIMIT as valid.

Reset
REQ-032 SHALL, on rst=1 at a rising edge, force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, store_count=0, timeout counter=0.
REQ-033 SHALL give rst priority over start and mem_ack in the same cycle.
REQ-034 SHALL, on rst during WRITE, drop mem_we at that edge with no done/err pulse.

Verification
REQ-035 Basic store: start, memory_addr=240, r1=255, mem_ack 3 cycles after mem_we rises -> mem_addr=240, mem_wdata=255 throughout WRITE, one done pulse, store_count=1.
REQ-036 Range: memory_addr=512, r1=7 -> err pulse, mem_we never high, store_count unchanged.
REQ-037 Boundary/timeout: memory_addr=511 with mem_ack held low -> mem_we high exactly 16 cycles, then err pulse; repeat with ack on 16th cycle -> done, no err.
REQ-038 Busy: second start with memory_addr=10 during WRITE -> ignored, mem_addr stays 240; r1 changed mid-WRITE -> mem_wdata unchanged.
REQ-039 Reset mid-op: rst during WRITE -> next cycle mem_we=0, busy=0, store_count=0, no done/err; fresh store then completes normally.
REQ-040 Wrap: preload 65535 successful stores -> next done sets store_count=0.
